// File: rtl/cpu_pkg.sv
// Shared types and constants for the decode/execute pipeline boundary.
package cpu_pkg;

    localparam int unsigned CW     = 8;
    localparam logic [3:0]  PC_REG = 4'd15;

    typedef struct packed {
        logic       reg_write;
        logic       memto_reg;
        logic       mem_write;
        logic       branch;
        logic       alu_src;
        logic [1:0] alu_control;
        logic       flag_w;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_fwd_sel.sv
// Operand forwarding mux: memory-stage writer wins over writeback; R15 is never forwarded.
module fwd_sel
    import cpu_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned M = 32
) (
    input  logic [N-1:0] ra,
    input  logic [M-1:0] rd,
    input  logic         reg_write_m,
    input  logic [N-1:0] wa3_m,
    input  logic [M-1:0] alu_result_m,
    input  logic         reg_write_w,
    input  logic [N-1:0] wa3_w,
    input  logic [M-1:0] result_w,
    output logic [M-1:0] fwd
);

    logic not_pc;
    assign not_pc = (ra != N'(PC_REG));

    always_comb begin
        fwd = rd;
        if (reg_write_m && (wa3_m == ra) && not_pc)
            fwd = alu_result_m;
        else if (reg_write_w && (wa3_w == ra) && not_pc)
            fwd = result_w;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with same-cycle W bypass, M/W forwarding and load-use stall.
// Optional performance counters are built when ID_EX_PERF_CNT_EN is defined.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned M  = 32,
    parameter int unsigned CW = cpu_pkg::CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ValidD,
    input  logic [N-1:0]  RA1D,
    input  logic [N-1:0]  RA2D,
    input  logic [N-1:0]  WA3D,
    input  logic [M-1:0]  RD1D,
    input  logic [M-1:0]  RD2D,
    input  logic [M-1:0]  ExtImmD,
    input  logic [CW-1:0] CtrlD,
    input  logic          FlushE,
    input  logic          HoldE,
    input  logic          RegWriteM,
    input  logic [N-1:0]  WA3M,
    input  logic [M-1:0]  ALUResultM,
    input  logic          RegWriteW,
    input  logic [N-1:0]  WA3W,
    input  logic [M-1:0]  ResultW,
    output logic          Stall,
    output logic          ValidE,
    output logic [CW-1:0] CtrlE,
    output logic [N-1:0]  WA3E,
    output logic [M-1:0]  SrcAE,
    output logic [M-1:0]  SrcBE,
    output logic [M-1:0]  WriteDataE,
    output logic [31:0]   StallCount,
    output logic [31:0]   FlushCount
);

    ctrl_t        ctrl_d;
    ctrl_t        ctrl_e;
    logic         valid_e;
    logic [N-1:0] wa3_e;
    logic [N-1:0] ra1_e;
    logic [N-1:0] ra2_e;
    logic [M-1:0] rd1_e;
    logic [M-1:0] rd2_e;
    logic [M-1:0] ext_imm_e;
    logic [M-1:0] fwd_a;
    logic [M-1:0] fwd_b;
    logic [M-1:0] byp1;
    logic [M-1:0] byp2;
    logic         lu;

    assign ctrl_d = ctrl_t'(CtrlD);

    // Register file writes on the same edge we capture, so its read data is one write stale.
    assign byp1 = (RegWriteW && (WA3W == RA1D) && (RA1D != N'(PC_REG))) ? ResultW : RD1D;
    assign byp2 = (RegWriteW && (WA3W == RA2D) && (RA2D != N'(PC_REG))) ? ResultW : RD2D;

    assign lu = valid_e && ctrl_e.memto_reg && ctrl_e.reg_write &&
                (wa3_e != N'(PC_REG)) && ValidD &&
                ((wa3_e == RA1D) || (wa3_e == RA2D));

    assign Stall = lu || HoldE;

    fwd_sel #(.N(N), .M(M)) u_fwd_a (
        .ra           (ra1_e),
        .rd           (rd1_e),
        .reg_write_m  (RegWriteM),
        .wa3_m        (WA3M),
        .alu_result_m (ALUResultM),
        .reg_write_w  (RegWriteW),
        .wa3_w        (WA3W),
        .result_w     (ResultW),
        .fwd          (fwd_a)
    );

    fwd_sel #(.N(N), .M(M)) u_fwd_b (
        .ra           (ra2_e),
        .rd           (rd2_e),
        .reg_write_m  (RegWriteM),
        .wa3_m        (WA3M),
        .alu_result_m (ALUResultM),
        .reg_write_w  (RegWriteW),
        .wa3_w        (WA3W),
        .result_w     (ResultW),
        .fwd          (fwd_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_e   <= 1'b0;
            ctrl_e    <= CTRL_BUBBLE;
            wa3_e     <= '0;
            ra1_e     <= '0;
            ra2_e     <= '0;
            rd1_e     <= '0;
            rd2_e     <= '0;
            ext_imm_e <= '0;
        end else if (FlushE) begin
            valid_e <= 1'b0;
            ctrl_e  <= CTRL_BUBBLE;
        end else if (HoldE) begin
            // Refresh operands so results retiring from M/W during the hold survive.
            rd1_e <= fwd_a;
            rd2_e <= fwd_b;
        end else if (lu) begin
            valid_e <= 1'b0;
            ctrl_e  <= CTRL_BUBBLE;
        end else begin
            valid_e   <= ValidD;
            ctrl_e    <= ValidD ? ctrl_d : CTRL_BUBBLE;
            wa3_e     <= WA3D;
            ra1_e     <= RA1D;
            ra2_e     <= RA2D;
            rd1_e     <= byp1;
            rd2_e     <= byp2;
            ext_imm_e <= ExtImmD;
        end
    end

    assign ValidE     = valid_e;
    assign CtrlE      = ctrl_e;
    assign WA3E       = wa3_e;
    assign SrcAE      = fwd_a;
    assign WriteDataE = fwd_b;
    assign SrcBE      = ctrl_e.alu_src ? ext_imm_e : fwd_b;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] stall_count;
    logic [31:0] flush_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (Stall)  stall_count <= stall_count + 32'd1;
            if (FlushE) flush_count <= flush_count + 32'd1;
        end
    end

    assign StallCount = stall_count;
    assign FlushCount = flush_count;
`else
    assign StallCount = '0;
    assign FlushCount = '0;
`endif

endmodule
